// File: rtl/rotr_seq.sv
// rotr_seq: bit-serial 32-bit shift-right / rotate-right, one bit per cycle (rotate only with ROTR_MODE_EN).
// Latency: done is high in the cycle after edge eff+2; start is ignored while busy (no queuing, no backpressure).
module rotr_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [5:0]  rightShift,
    input  logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic [31:0] shiftedData
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_work;
    logic [31:0] w_work_nxt;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nxt;
    logic [31:0] r_result;
    logic [31:0] w_result_nxt;
    logic [5:0]  w_eff;
    logic        w_fill;
    logic [5:0]  w_shr_eff;

    // Logical shifts saturate at 32: anything larger would still leave all zeros.
    assign w_shr_eff = rightShift[5] ? 6'd32 : rightShift;

`ifdef ROTR_MODE_EN
    logic r_mode;
    logic w_mode_nxt;

    assign w_eff  = mode ? {1'b0, rightShift[4:0]} : w_shr_eff;
    assign w_fill = r_mode & r_work[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= 1'b0;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (r_state == S_IDLE && start) begin
            w_mode_nxt = mode;
        end
    end
`else
    logic w_unused_mode;

    assign w_unused_mode = mode;
    assign w_eff         = w_shr_eff;
    assign w_fill        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_work   <= w_work_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_work_nxt   = r_work;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_work_nxt  = data;
                    w_cnt_nxt   = w_eff;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt != 6'd0) begin
                    w_work_nxt = {w_fill, r_work[31:1]};
                    w_cnt_nxt  = r_cnt - 6'd1;
                end else begin
                    w_result_nxt = r_work;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign shiftedData = r_result;

endmodule

// File: tb/tb_rotr_seq.sv
// Self-checking bench for rotr_seq: directed vector table, hand sequences, and randomized ops vs a reference model.
module tb_rotr_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [5:0]  rightShift;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic [31:0] shiftedData;

    int checks;
    int errors;
    logic [31:0] last_res;

    rotr_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .rightShift (rightShift),
        .data       (data),
        .busy       (busy),
        .done       (done),
        .shiftedData(shiftedData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] d;
        logic [5:0]  sh;
        logic        m;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: effective amount and result from plain arithmetic.
    function automatic int ref_eff(input logic [5:0] sh, input logic m);
`ifdef ROTR_MODE_EN
        if (m) return int'(sh) % 32;
`endif
        return (int'(sh) > 32) ? 32 : int'(sh);
    endfunction

    function automatic logic [31:0] ref_res(input logic [31:0] d, input logic [5:0] sh, input logic m);
        logic [63:0] dd;
`ifdef ROTR_MODE_EN
        if (m) begin
            dd = {d, d} >> (int'(sh) % 32);
            return dd[31:0];
        end
`endif
        if (int'(sh) >= 32) return 32'h0;
        return d >> sh;
    endfunction

    task automatic run_op(input string name, input logic [31:0] d, input logic [5:0] sh,
                          input logic m, input logic [31:0] exp_res, input int exp_lat);
        int edges;
        int busy_bad;
        int hold_bad;
        @(negedge clk);
        data = d; rightShift = sh; mode = m; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        data = $urandom;
        rightShift = 6'($urandom_range(0, 63));
        mode = ~m;
        edges = 1; busy_bad = 0; hold_bad = 0;
        @(negedge clk);
        while (!done && edges < 80) begin
            if (busy !== 1'b1) busy_bad++;
            if (shiftedData !== last_res) hold_bad++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({name, " latency"}, 32'(edges), 32'(exp_lat));
        check({name, " busy_during"}, 32'(busy_bad), 32'd0);
        check({name, " hold_during"}, 32'(hold_bad), 32'd0);
        check({name, " done"}, {31'd0, done}, 32'd1);
        check({name, " busy_in_done"}, {31'd0, busy}, 32'd1);
        check({name, " result"}, shiftedData, exp_res);
        last_res = exp_res;
        @(posedge clk);
        @(negedge clk);
        check({name, " done_one_cycle"}, {31'd0, done}, 32'd0);
        check({name, " idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic        hd_done[13];
        logic        hd_busy[13];
        logic [31:0] hd_sd[13];
        int          npulse;
        logic [31:0] rd;
        logic [5:0]  rs;
        logic        rm;

        checks = 0; errors = 0; last_res = 32'h0;
        rst = 1'b1; start = 1'b0; mode = 1'b0; rightShift = 6'd0; data = 32'h0;

        vecs[0] = '{"shr4",    32'h80000000, 6'd4,  1'b0, 32'h08000000, 6};
        vecs[1] = '{"zero",    32'hDEADBEEF, 6'd0,  1'b0, 32'hDEADBEEF, 2};
        vecs[2] = '{"shr40",   32'hFFFFFFFF, 6'd40, 1'b0, 32'h00000000, 34};
        vecs[3] = '{"shr32",   32'h12345678, 6'd32, 1'b0, 32'h00000000, 34};
        vecs[4] = '{"shr31",   32'hF0000000, 6'd31, 1'b0, 32'h00000001, 33};
`ifdef ROTR_MODE_EN
        vecs[5] = '{"rot1",    32'h00000001, 6'd1,  1'b1, 32'h80000000, 3};
        vecs[6] = '{"rot40",   32'h000000FF, 6'd40, 1'b1, 32'hFF000000, 10};
        vecs[7] = '{"rot32",   32'hA5A5A5A5, 6'd32, 1'b1, 32'hA5A5A5A5, 2};
`else
        vecs[5] = '{"m1_shr1", 32'h00000001, 6'd1,  1'b1, 32'h00000000, 3};
        vecs[6] = '{"m1_shr40",32'h000000FF, 6'd40, 1'b1, 32'h00000000, 34};
        vecs[7] = '{"m1_shr32",32'hA5A5A5A5, 6'd32, 1'b1, 32'h00000000, 34};
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset data", shiftedData, 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].d, vecs[i].sh, vecs[i].m, vecs[i].exp, vecs[i].lat);
        end

        // start held high throughout: one pulse, DONE-cycle start ignored, re-accepted from IDLE.
        @(negedge clk);
        data = 32'h80000000; rightShift = 6'd4; mode = 1'b0; start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                data = 32'hFFFFFFFF;
                rightShift = 6'd0;
            end
            if (k == 8) start = 1'b0;
            @(negedge clk);
            hd_done[k] = done;
            hd_busy[k] = busy;
            hd_sd[k]   = shiftedData;
        end
        npulse = 0;
        for (int k = 1; k <= 7; k++) if (hd_done[k]) npulse++;
        check("held pulses_first", 32'(npulse), 32'd1);
        check("held done_e6", {31'd0, hd_done[6]}, 32'd1);
        check("held result1", hd_sd[6], 32'h08000000);
        check("held idle_e7", {31'd0, hd_busy[7]}, 32'd0);
        check("held busy_e8", {31'd0, hd_busy[8]}, 32'd1);
        check("held done_e9", {31'd0, hd_done[9]}, 32'd1);
        check("held result2", hd_sd[9], 32'hFFFFFFFF);
        check("held idle_e10", {31'd0, hd_busy[10]}, 32'd0);
        last_res = 32'hFFFFFFFF;

        // Reset mid-SHIFT aborts with no done pulse.
        @(negedge clk);
        data = 32'hFFFFFFFF; rightShift = 6'd20; mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst done", {31'd0, done}, 32'd0);
        check("midrst data", shiftedData, 32'h0);
        npulse = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) npulse++;
        end
        check("midrst no_pulse", 32'(npulse), 32'd0);
        last_res = 32'h0;
        run_op("after_rst", 32'h0000F000, 6'd12, 1'b0, 32'h0000000F, 14);

        for (int n = 0; n < 40; n++) begin
            rd = $urandom;
            rs = 6'($urandom_range(0, 63));
            rm = 1'($urandom_range(0, 1));
            run_op("rand", rd, rs, rm, ref_res(rd, rs, rm), ref_eff(rs, rm) + 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotr_seq.md
ROTR_SEQ -- requirements
Module: rotr_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, sampled only on the rising edge of clk.
REQ-002 The block SHALL have these ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- mode  input  1  operation: 0 = logical shift right (SHR), 1 = rotate right (ROTR).
- rightShift  input  6  requested shift amount, 0..63.
- data  input  32  operand.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- shiftedData  output  32  registered result; holds its value between operations.

Function
REQ-003 The block SHALL implement the states IDLE, SHIFT and DONE.
REQ-004 In IDLE with start=1, one edge SHALL load the work register with data, latch mode, load cnt with eff, and go to SHIFT.
REQ-005 For SHR, eff SHALL be min(rightShift, 32); for ROTR, eff SHALL be rightShift[4:0] (modulo 32).
REQ-006 In SHIFT with cnt!=0, each edge SHALL move the work register right by exactly 1 bit and decrement cnt.
- SHR fills bit 31 with 0.
- ROTR moves old bit 0 into bit 31.
REQ-007 In SHIFT with cnt==0, the next edge SHALL copy the work register to shiftedData and go to DONE.
REQ-008 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return the block to IDLE.
REQ-009 Latency SHALL be fixed. Counting the edge that samples start as edge 1, done is high in the cycle after edge eff+2.
REQ-010 start while busy=1 SHALL be ignored, with no queuing and no change to the operation in flight.
REQ-011 start in the DONE cycle SHALL be ignored; a new start is accepted only in IDLE.
REQ-012 data, rightShift and mode SHALL be sampled only on the accepting edge; later changes SHALL have no effect.
REQ-013 shiftedData SHALL change only on the SHIFT->DONE edge or on reset.
REQ-014 eff=0 SHALL give shiftedData equal to data, with done after edge 2.
REQ-015 SHR with rightShift>=32 SHALL give 0x00000000 after 32 shift cycles.

Reset
REQ-016 rst=1 SHALL take priority over all other inputs.
REQ-017 On reset the block SHALL force:
- state IDLE, cnt 0, work register 0, latched mode 0;
- busy 0, done 0, shiftedData 0x00000000.
REQ-018 Reset during SHIFT or DONE SHALL abort the operation with no done pulse.
REQ-019 The first start after rst falls SHALL be accepted normally.

Configuration
REQ-020 With macro ROTR_MODE_EN defined, mode SHALL select SHR or ROTR as specified in REQ-005 and REQ-006.
REQ-021 Without ROTR_MODE_EN, mode SHALL be ignored, every operation SHALL be SHR, and no rotate logic SHALL be synthesized.

Verification
REQ-022 SHR shift, rotate wrap and zero amount:
- mode=0, data=0x80000000, rightShift=4 -> shiftedData=0x08000000, done after edge 6, busy high edges 1..7.
- ROTR_MODE_EN, mode=1, data=0x00000001, rightShift=1 -> shiftedData=0x80000000, done after edge 3.
- rightShift=0, data=0xDEADBEEF -> shiftedData=0xDEADBEEF, done after edge 2.
REQ-023 Amounts of 32 or more:
- mode=0, rightShift=40, data=0xFFFFFFFF -> 0x00000000, done after edge 34.
- ROTR_MODE_EN, mode=1, rightShift=40, data=0x000000FF -> 0xFF000000, done after edge 10.
REQ-024 Busy-start and mid-operation reset:
- start=1 held during the whole operation -> exactly one done pulse, then a second operation starts from IDLE.
- rst pulsed mid-SHIFT -> busy=0, done=0, shiftedData=0 next cycle, no done pulse.
REQ-025 Build without ROTR_MODE_EN; mode=1, data=0x00000001, rightShift=1 -> shiftedData=0x00000000 (SHR result).
